// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, FSM states and Booth digit-select type (no config macros here)
package booth_pkg;
    localparam int MANT_W_DEF = 24;
    localparam int NDIG = MANT_W_DEF / 2 + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic single;
        logic dbl;
        logic neg;
    } booth_sel_t;
endpackage

// File: rtl/booth_enc_r4.sv
// booth_enc_r4: radix-4 Booth recoder, triplet {b[2i+1],b[2i],b[2i-1]} -> {single,double,neg}
module booth_enc_r4
    import booth_pkg::*;
(
    input  logic [2:0] trip,
    output booth_sel_t sel
);
    assign sel = {trip[1] ^ trip[0], (trip == 3'b011) || (trip == 3'b100), trip[2]};
endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-4 Booth multiplier, one digit per cycle; BOOTH_EARLY_TERM_EN stops once the remaining multiplier bits are zero
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANT_W-1:0]   a,
    input  logic [MANT_W-1:0]   b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*MANT_W-1:0] product,
    output logic [2:0]          sel
);
    localparam int ND = MANT_W / 2 + 1;
    localparam int CW = $clog2(ND);
    localparam int AW = 2 * MANT_W + 3;
    localparam int BW = MANT_W + 3;

    state_t            state;
    logic [MANT_W-1:0] a_r, b_r;
    logic [CW-1:0]     i;
    logic [AW-1:0]     acc, mag, pp, acc_nx;
    logic [BW-1:0]     bx;
    logic [2:0]        trip;
    booth_sel_t        dsel;
    logic              last;

    // b with an implicit zero below bit 0 and zeros above the top bit
    assign bx   = {2'b00, b_r, 1'b0};
    assign trip = 3'(bx >> {i, 1'b0});

    booth_enc_r4 u_enc (.trip(trip), .sel(dsel));

    assign mag    = dsel.dbl ? AW'({a_r, 1'b0}) : dsel.single ? AW'(a_r) : '0;
    assign pp     = mag << {i, 1'b0};
    assign acc_nx = dsel.neg ? acc - pp : acc + pp;

`ifdef BOOTH_EARLY_TERM_EN
    // stop when every multiplier bit from b[2i+1] upward is zero
    assign last = (i == CW'(ND - 1)) || (((bx >> {i, 1'b0}) >> 2) == '0);
`else
    assign last = (i == CW'(ND - 1));
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sel       = (state == RUN) ? dsel : 3'b000;

    // FSM, digit counter and accumulator; product captured on the final digit
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            i       <= '0;
            acc     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    i     <= '0;
                    acc   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc <= acc_nx;
                    i   <= i + 1'b1;
                    if (last) begin
                        state   <= DONE;
                        product <= acc_nx[2*MANT_W-1:0];
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: table-driven and directed checks of booth_seq_mul (MANT_W=24)
module tb_booth_seq_mul;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [23:0] a, b;
    logic [47:0] product;
    logic [2:0]  sel;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [2:0]  sels [16];

    booth_seq_mul dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .sel(sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [23:0] bv);
`ifdef BOOTH_EARLY_TERM_EN
        for (int k = 1; k <= 13; k++)
            if ((bv >> (2 * k - 1)) == 24'd0) return k;
`endif
        return 13;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [23:0] av, input logic [23:0] bv, input logic [47:0] pe, input int hold);
        int cnt;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step;
            w++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        a = av;
        b = bv;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        a = 24'($urandom);
        b = 24'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            if (cnt < 16) sels[cnt] = sel;
            step;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(exp_lat(bv)));
        chk("product", 64'(product), 64'(pe));
        chk("sel_done", 64'(sel), 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 24'($urandom);
            b = 24'($urandom);
            step;
            chk("hold_state", {61'd0, out_valid, in_ready, 1'b0}, 64'b100);
            chk("hold_product", 64'(product), 64'(pe));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        chk("release", {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        vec_t vt [12];
        logic seen;
        logic [23:0] ra, rb;
        vt[0]  = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0};
        vt[1]  = '{24'h800000, 24'h800000, 48'h400000000000, 0};
        vt[2]  = '{24'h000000, 24'h000000, 48'h000000000000, 0};
        vt[3]  = '{24'h000001, 24'h000001, 48'h000000000001, 1};
        vt[4]  = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 0};
        vt[5]  = '{24'hC00001, 24'h000001, 48'h000000C00001, 0};
        vt[6]  = '{24'hC00001, 24'h000002, 48'h000001800002, 2};
        vt[7]  = '{24'h7FFFFF, 24'h7FFFFF, 48'h3FFFFF000001, 0};
        vt[8]  = '{24'h000003, 24'hAAAAAA, 48'h000001FFFFFE, 0};
        vt[9]  = '{24'h000100, 24'h010000, 48'h000001000000, 0};
        vt[10] = '{24'hABCDEF, 24'h000010, 48'h00000ABCDEF0, 5};
        vt[11] = '{24'hFFFFFF, 24'h000000, 48'h000000000000, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        step;
        step;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        chk("reset_sel", 64'(sel), 64'd0);
        rst = 1'b0;
        step;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < 12; k++) op(vt[k].a, vt[k].b, vt[k].p, vt[k].hold);

        op(24'h800000, 24'h800000, 48'h400000000000, 0);
        for (int k = 0; k < 11; k++) chk("sel_low_digit", 64'(sels[k]), 64'd0);
        chk("sel_digit11", 64'(sels[11]), 64'b011);
        chk("sel_digit12", 64'(sels[12]), 64'b100);

        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step;
        chk("abort_running", {62'd0, out_valid, in_ready}, 64'b00);
        rst = 1'b1;
        in_valid = 1'b1;
        step;
        chk("abort_state", {61'd0, out_valid, in_ready, sel == 3'b000}, 64'b011);
        chk("abort_product", 64'(product), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step;
            seen |= out_valid;
        end
        chk("abort_no_stale", {63'd0, seen}, 64'd0);
        chk("abort_product_held", 64'(product), 64'd0);

        for (int k = 0; k < 1500; k++) begin
            ra = 24'($urandom);
            rb = (k % 4 == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
            op(ra, rb, {24'd0, ra} * {24'd0, rb}, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
